// File: rtl/fu_pkg.sv
// Shared definitions for the function-unit op sequencer: FS encodings,
// controller states and default widths.
package fu_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [4:0] FS_TRANSFER_A = 5'b00000;
    localparam logic [4:0] FS_ADD        = 5'b00010;
    localparam logic [4:0] FS_SUB        = 5'b00101;
    localparam logic [4:0] FS_AND        = 5'b01000;
    localparam logic [4:0] FS_PASS_B     = 5'b10000;
    localparam logic [4:0] FS_SHL        = 5'b10001;
    localparam logic [4:0] FS_SHR        = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Shift ops are the FS[4]=1 codes other than the plain B transfer.
    function automatic logic is_shift_fs(input logic [4:0] fs);
        return fs[4] && (fs[3:0] != 4'd0);
    endfunction

endpackage

// File: rtl/fu_op_sequencer.sv
// Initiator-side controller for function_unit: issues one pass per cycle,
// iterating the single-bit shifter for multi-bit shifts, and returns F plus flags.
module fu_op_sequencer
    import fu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         req_fs,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_f,
    output logic               rsp_v,
    output logic               rsp_c,
    output logic               rsp_n,
    output logic               rsp_z,
    output logic [DATA_W-1:0]  fu_busA,
    output logic [DATA_W-1:0]  fu_busB,
    output logic [4:0]         fu_fs,
    input  logic [DATA_W-1:0]  fu_f,
    input  logic               fu_v,
    input  logic               fu_c,
    input  logic               fu_n,
    input  logic               fu_z
);

    state_t               state;
    state_t               next_state;
    logic [4:0]           fs_reg;
    logic [DATA_W-1:0]    a_reg;
    logic [DATA_W-1:0]    b_reg;
    logic [SHAMT_W-1:0]   cnt;
    logic                 feedback;
    logic                 accept;
    logic                 last_pass;
    logic                 req_shift;
    logic                 req_zero_shamt;

    assign accept         = req_valid && req_ready;
    assign last_pass      = (cnt == SHAMT_W'(1));
    assign req_shift      = is_shift_fs(req_fs);
    assign req_zero_shamt = (req_shamt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)    next_state = ST_EXEC;
            ST_EXEC: if (last_pass) next_state = ST_RESP;
            ST_RESP: if (rsp_ready) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && !rst;
        rsp_valid = (state == ST_RESP);
        fu_busA   = '0;
        fu_busB   = '0;
        fu_fs     = FS_TRANSFER_A;
        if (state == ST_EXEC) begin
            fu_busA = a_reg;
            fu_busB = b_reg;
            fu_fs   = fs_reg;
        end
    end

    // A zero-length shift degenerates into a single B transfer so the result is B.
    always_ff @(posedge clk) begin
        if (accept) begin
            fs_reg   <= (req_shift && req_zero_shamt) ? FS_PASS_B : req_fs;
            a_reg    <= req_a;
            b_reg    <= req_b;
            cnt      <= (req_shift && !req_zero_shamt) ? req_shamt : SHAMT_W'(1);
            feedback <= req_shift && !req_zero_shamt;
        end else if (state == ST_EXEC) begin
            if (feedback) b_reg <= fu_f;
            cnt <= cnt - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_f <= '0;
            rsp_v <= 1'b0;
            rsp_c <= 1'b0;
            rsp_n <= 1'b0;
            rsp_z <= 1'b0;
        end else if (state == ST_EXEC && last_pass) begin
            rsp_f <= fu_f;
            rsp_v <= fu_v;
            rsp_c <= fu_c;
            rsp_n <= fu_n;
            rsp_z <= fu_z;
        end
    end

endmodule

// File: tb/tb_fu_op_sequencer.sv
// Bench for fu_op_sequencer: a behavioural function_unit drives the fu_* inputs,
// and each operation's timing, bus activity and response are checked against a reference.
module tb_fu_op_sequencer;
    import fu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_fs;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_f;
    logic        rsp_v, rsp_c, rsp_n, rsp_z;
    logic [31:0] fu_busA, fu_busB;
    logic [4:0]  fu_fs;
    logic [31:0] fu_f;
    logic        fu_v, fu_c, fu_n, fu_z;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_f;
    logic [3:0]  last_flags;

    logic        offer_next;
    logic [4:0]  nxt_fs;
    logic [31:0] nxt_a, nxt_b;
    logic [4:0]  nxt_shamt;

    always #5 clk = ~clk;

    fu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fs(req_fs),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .rsp_v(rsp_v), .rsp_c(rsp_c), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .fu_busA(fu_busA), .fu_busB(fu_busB), .fu_fs(fu_fs),
        .fu_f(fu_f), .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z)
    );

    // Behavioural function unit: returns {V, C, N, Z, F}.
    function automatic logic [35:0] fu_calc(input logic [4:0] fs, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] f;
        logic        v, c;
        f = 32'd0; v = 1'b0; c = 1'b0; s = 33'd0;
        case (fs)
            FS_TRANSFER_A: f = a;
            FS_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                f = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (f[31] != a[31]);
            end
            FS_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                f = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (f[31] != a[31]);
            end
            FS_AND:    f = a & b;
            FS_PASS_B: f = b;
            FS_SHL:    begin f = b << 1; c = b[31]; end
            FS_SHR:    begin f = b >> 1; c = b[0];  end
            default:   f = 32'd0;
        endcase
        return {v, c, f[31], (f == 32'd0), f};
    endfunction

    always_comb {fu_v, fu_c, fu_n, fu_z, fu_f} = fu_calc(fu_fs, fu_busA, fu_busB);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A shift of N passes ends with one FU pass applied to B already moved N-1 places.
    task automatic do_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] shamt, input int stall);
        int          n;
        logic        shift;
        logic [4:0]  eff_fs;
        logic [31:0] exp_b;
        logic [35:0] ref_rsp;
        shift   = fs[4] && (fs[3:0] != 4'd0);
        n       = (shift && shamt != 5'd0) ? int'(shamt) : 1;
        eff_fs  = (shift && shamt == 5'd0) ? FS_PASS_B : fs;
        if (shift && shamt != 5'd0)
            exp_b = (fs == FS_SHL) ? (b << (shamt - 5'd1)) : (b >> (shamt - 5'd1));
        else
            exp_b = b;
        ref_rsp = fu_calc(eff_fs, a, exp_b);

        req_fs = fs; req_a = a; req_b = b; req_shamt = shamt; req_valid = 1'b1;
        rsp_ready = (stall > 0) ? 1'b0 : 1'b1;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_fs = 5'b11111; req_shamt = 5'd31;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("exec_req_ready", {31'd0, req_ready}, 32'd0);
            chk("exec_fu_fs", {27'd0, fu_fs}, {27'd0, eff_fs});
            chk("exec_fu_busA", fu_busA, a);
            if (shift && shamt != 5'd0)
                chk("exec_fu_busB", fu_busB,
                    (fs == FS_SHL) ? (b << (k - 1)) : (b >> (k - 1)));
            else
                chk("exec_fu_busB", fu_busB, b);
        end
        @(negedge clk);
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_f", rsp_f, ref_rsp[31:0]);
        chk("resp_flags", {28'd0, rsp_v, rsp_c, rsp_n, rsp_z}, {28'd0, ref_rsp[35:32]});
        chk("resp_fu_idle", fu_busA | fu_busB | {27'd0, fu_fs}, 32'd0);
        chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
        last_f     = rsp_f;
        last_flags = {rsp_v, rsp_c, rsp_n, rsp_z};
        for (int s = 0; s < stall; s++) begin
            if (offer_next) begin
                req_fs = nxt_fs; req_a = nxt_a; req_b = nxt_b; req_shamt = nxt_shamt;
                req_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_f", rsp_f, last_f);
            chk("stall_flags", {28'd0, rsp_v, rsp_c, rsp_n, rsp_z}, {28'd0, last_flags});
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_fu_idle", fu_busA | fu_busB | {27'd0, fu_fs}, 32'd0);
    endtask

    initial begin
        logic [4:0] fs_tab [7];
        fs_tab = '{FS_TRANSFER_A, FS_ADD, FS_SUB, FS_AND, FS_PASS_B, FS_SHL, FS_SHR};
        offer_next = 1'b0;
        nxt_fs = 5'd0; nxt_a = 32'd0; nxt_b = 32'd0; nxt_shamt = 5'd0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_fs = 5'd0; req_a = 32'd0; req_b = 32'd0; req_shamt = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_f", rsp_f, 32'd0);
        chk("rst_flags", {28'd0, rsp_v, rsp_c, rsp_n, rsp_z}, 32'd0);
        chk("rst_fu", fu_busA | fu_busB | {27'd0, fu_fs}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        do_op(FS_ADD, 32'd5, 32'd3, 5'd0, 0);
        chk("add_f", last_f, 32'h8);
        chk("add_flags", {28'd0, last_flags}, 32'd0);

        do_op(FS_SUB, 32'd3, 32'd5, 5'd7, 0);
        chk("sub_f", last_f, 32'hFFFF_FFFE);
        chk("sub_n", {31'd0, last_flags[1]}, 32'd1);
        chk("sub_z", {31'd0, last_flags[0]}, 32'd0);

        do_op(FS_SHL, 32'd0, 32'h3, 5'd4, 0);
        chk("shl4_f", last_f, 32'h30);

        do_op(FS_SHL, 32'd0, 32'h1234, 5'd0, 0);
        chk("shl0_f", last_f, 32'h1234);

        do_op(FS_SHR, 32'd0, 32'h8000_0000, 5'd31, 0);
        chk("shr31_f", last_f, 32'h1);

        offer_next = 1'b1;
        nxt_fs = FS_ADD; nxt_a = 32'd1; nxt_b = 32'd1; nxt_shamt = 5'd0;
        do_op(FS_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 3);
        chk("bp_and_f", last_f, 32'h00F0_1234);
        offer_next = 1'b0;
        do_op(nxt_fs, nxt_a, nxt_b, nxt_shamt, 0);
        chk("bp_next_f", last_f, 32'h2);

        req_fs = FS_SHL; req_a = 32'd0; req_b = 32'h1; req_shamt = 5'd10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_exec_fs", {27'd0, fu_fs}, {27'd0, FS_SHL});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_fu", fu_busA | fu_busB | {27'd0, fu_fs}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        do_op(FS_ADD, 32'd5, 32'd3, 5'd0, 0);
        chk("after_rst_add_f", last_f, 32'h8);

        for (int i = 0; i < 25; i++) begin
            do_op(fs_tab[$urandom_range(0, 6)], $urandom, $urandom,
                  5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_op_sequencer.md
# fu_op_sequencer

Initiator-side controller for the 32-bit `function_unit`: accepts operation requests over a valid/ready handshake and drives `busA`/`busB`/`FS` into the function unit. It captures `F` and the flags V/C/N/Z and returns them over a valid/ready response channel. Multi-bit shifts are built by iterating the function unit's single-bit shifter, feeding `F` back into `busB` each pass. It sits between the control/decode stage and the `function_unit` instance in the datapath top.

## Interface
- `DATA_W`, 32, operand/result width; fixed to match `function_unit`.
- `SHAMT_W`, 5, shift-amount width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_fs`  in  5  function select, function_unit encoding.
- `req_a`  in  DATA_W  operand A.
- `req_b`  in  DATA_W  operand B.
- `req_shamt`  in  SHAMT_W  shift count; used only for shift ops.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_f`  out  DATA_W  result.
- `rsp_v`, `rsp_c`, `rsp_n`, `rsp_z`  out  1 each  flags from the final pass.
- `fu_busA`, `fu_busB`  out  DATA_W  to function_unit.
- `fu_fs`  out  5  to function_unit `FS`.
- `fu_f`  in  DATA_W  from function_unit `F`.
- `fu_v`, `fu_c`, `fu_n`, `fu_z`  in  1 each  from function_unit.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready`=1 (0 while `rst`=1).
  - On `req_valid && req_ready`, latch fs, A, B and the pass count, then go to EXEC.
- **Op classes**
  - `req_fs[4]`=0 (arithmetic/logic): pass count 1; shamt ignored.
  - `req_fs`=10000 (transfer B): pass count 1.
  - `req_fs[4]`=1 with `req_fs[3:0]`≠0 (shift):
    - Pass count = shamt.
    - If shamt=0, issue a single pass with FS forced to 10000, so the result is B unchanged.
- **EXEC** (one pass per cycle)
  - Drive `fu_busA`=A_reg, `fu_busB`=B_reg, `fu_fs`=fs_reg.
  - Shift ops: B_reg ← `fu_f` at the end of every pass.
  - Decrement count each pass.
  - On the last pass (count=1), register `fu_f` and all four flags into the rsp registers, then go to RESP.
- **RESP**
  - `rsp_valid`=1; rsp outputs are held stable.
  - On `rsp_ready`=1, go to IDLE.
  - `req_ready`=0 throughout EXEC and RESP (no overlap).
- `fu_*` outputs are 0 (`fu_fs`=00000) in IDLE and RESP.
- No arithmetic is done locally. The function unit's flags pass through unmodified, including its carry/borrow convention.

## Timing
- Reset: state=IDLE.
  - `rsp_valid`=0; `rsp_f`=0; flags=0.
  - `fu_busA`=`fu_busB`=0; `fu_fs`=0.
  - `req_ready`=1 from the first cycle after `rst` deasserts.
- Latency:
  - Accept edge at cycle 0; EXEC occupies cycles 1..N, where N = pass count (1 ≤ N ≤ 31).
  - `rsp_valid` rises in cycle N+1.
  - With `rsp_ready` held high, IDLE is re-entered at cycle N+2. Throughput is one op per N+2 cycles.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely, with `rsp_*` stable and `req_ready`=0.
- `req_valid` while busy has no effect. Requesters must hold it until the handshake (standard valid/ready).
- Reset mid-EXEC or mid-RESP: the next cycle is IDLE and the in-flight op is discarded. `rsp_valid`=0 and no response is emitted.
- Any `req_*` change after acceptance has no effect on the in-flight op.

## Structure
- Shared package `fu_pkg`:
  - FS constants: `FS_TRANSFER_A`=00000, `FS_ADD`=00010, `FS_SUB`=00101, `FS_AND`=01000, `FS_PASS_B`=10000, `FS_SHL`=10001, `FS_SHR`=10010.
  - State enum (IDLE/EXEC/RESP).
  - `DATA_W`/`SHAMT_W` defaults.
- No sub-module. A single FSM plus datapath registers. `function_unit` is instantiated alongside it in the datapath top, not inside.

## Test plan
- ADD: A=5, B=3, FS=00010 → `rsp_f`=0x00000008, V=C=N=Z=0; `rsp_valid` 2 cycles after accept.
- SUB: A=3, B=5, FS=00101 → `rsp_f`=0xFFFFFFFE, N=1, Z=0. C and V match the function unit's flag outputs for this operation.
- Shift left: B=0x3, FS=10001, shamt=4 → `fu_busB` steps 3,6,0xC,0x18 over 4 EXEC cycles; `rsp_f`=0x30; `rsp_valid` 5 cycles after accept.
- Shift with shamt=0: FS=10001, B=0x1234 → a single pass with `fu_fs`=10000; `rsp_f`=0x1234; latency 2.
- Backpressure: `rsp_ready`=0 for 3 cycles after `rsp_valid` → `rsp_f`/flags stable and `req_ready`=0. A new request offered meanwhile is accepted only after the response handshake.
- Reset mid-EXEC during a shamt=10 shift → next cycle IDLE, `rsp_valid`=0, `fu_*`=0, `req_ready`=1. A following ADD 5+3 returns 8.
